led_position_display: RTL and testbench



---
 rtl/led_disp_pkg.sv | 30 +++
 rtl/pos_avg_filter.sv | 59 +++++
 rtl/led_position_display.sv | 110 +++++++++++
 tb/tb_led_position_display.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/led_disp_pkg.sv
// rtl/led_disp_pkg.sv - shared types and constants for the LED position display
// Purpose: display state encoding, LED constants and the position-to-pattern helper.
package led_disp_pkg;

    localparam int LED_N = 16;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        STALE
    } disp_state_t;

    localparam logic [LED_N-1:0] BLINK_ON  = 16'hFFFF;
    localparam logic [LED_N-1:0] BLINK_OFF = 16'h0000;

    // Dot mode lights only LED idx. Bar mode lights LEDs 0..idx.
    // The bar value is formed in 17 bits so idx=15 yields all ones
    // without overflowing.
    function automatic logic [LED_N-1:0] map_pattern(input logic [3:0] idx,
                                                     input logic       bar);
        logic [LED_N-1:0] pat;
        if (bar) begin
            pat = LED_N'((17'd2 << idx) - 17'd1);
        end else begin
            pat = LED_N'(17'd1 << idx);
        end
        return pat;
    endfunction

endpackage

// File: rtl/pos_avg_filter.sv
// rtl/pos_avg_filter.sv - moving-average filter over position samples
// Purpose: 2^AVG_LOG2-deep moving average with a running sum.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   din        input sample
//   din_valid  sample strobe, always accepted
//   prefill    with din_valid: load din into every entry (restart the average)
//   avg        sum >> AVG_LOG2, truncating
//   avg_valid  high once any sample has been accepted since reset
module pos_avg_filter #(
    parameter int DATA_W   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              prefill,
    output logic [DATA_W-1:0] avg,
    output logic              avg_valid
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;

    logic [DATA_W-1:0]   entry_q [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr;
    logic [SUM_W-1:0]    sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            wr_ptr    <= '0;
            sum       <= '0;
            avg_valid <= 1'b0;
        end else if (din_valid) begin
            avg_valid <= 1'b1;
            if (prefill) begin
                // A restarted average is seeded entirely with the new sample
                // so early outputs never blend with old or zero entries.
                for (int i = 0; i < DEPTH; i++) begin
                    entry_q[i] <= din;
                end
                sum    <= SUM_W'(din) << AVG_LOG2;
                wr_ptr <= '0;
            end else begin
                // The entry at wr_ptr is the oldest sample in the window.
                entry_q[wr_ptr] <= din;
                sum    <= sum - SUM_W'(entry_q[wr_ptr]) + SUM_W'(din);
                wr_ptr <= wr_ptr + AVG_LOG2'(1);
            end
        end
    end

    assign avg = sum[SUM_W-1:AVG_LOG2];

endmodule

// File: rtl/led_position_display.sv
// rtl/led_position_display.sv - averaged servo position to 16-LED pattern with link supervision
// Purpose: filters position samples, maps them to a dot/bar pattern and blinks
//          all LEDs when samples stop arriving.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   pos_data   position sample
//   pos_valid  one-cycle sample strobe, no backpressure
//   mode       0 = dot, 1 = bar
//   led_on     registered LED pattern to the PWM stage
//   link_ok    registered, high while tracking live samples
module led_position_display
    import led_disp_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int BLINK_CYCLES   = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pos_data,
    input  logic              pos_valid,
    input  logic              mode,
    output logic [LED_N-1:0]  led_on,
    output logic              link_ok
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    disp_state_t       state;
    logic [TO_W-1:0]   to_cnt;
    logic [BL_W-1:0]   bl_cnt;
    logic              blink_off;
    logic              prefill;
    logic [DATA_W-1:0] avg;
    logic              avg_valid;
    logic [LED_N-1:0]  pattern;

    // Any sample arriving while not tracking restarts the average.
    assign prefill = pos_valid && (state != TRACK);
    assign pattern = map_pattern(avg[DATA_W-1 -: 4], mode);

    pos_avg_filter #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .din       (pos_data),
        .din_valid (pos_valid),
        .prefill   (prefill),
        .avg       (avg),
        .avg_valid (avg_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            to_cnt    <= '0;
            bl_cnt    <= '0;
            blink_off <= 1'b0;
            led_on    <= BLINK_OFF;
            link_ok   <= 1'b0;
        end else begin
            link_ok <= (state == TRACK);
            case (state)
                IDLE: begin
                    led_on <= BLINK_OFF;
                    if (pos_valid) begin
                        state  <= TRACK;
                        to_cnt <= '0;
                    end
                end
                TRACK: begin
                    led_on <= avg_valid ? pattern : BLINK_OFF;
                    // A sample on the expiry cycle keeps the link alive.
                    if (pos_valid) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        state     <= STALE;
                        bl_cnt    <= '0;
                        blink_off <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                STALE: begin
                    led_on <= blink_off ? BLINK_OFF : BLINK_ON;
                    if (pos_valid) begin
                        state  <= TRACK;
                        to_cnt <= '0;
                    end else if (bl_cnt == BL_LAST) begin
                        bl_cnt    <= '0;
                        blink_off <= ~blink_off;
                    end else begin
                        bl_cnt <= bl_cnt + BL_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    led_on <= BLINK_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_position_display.sv
// tb/tb_led_position_display.sv - self-checking bench for led_position_display
module tb_led_position_display;

    localparam int DATA_W  = 8;
    localparam int AVG_L2  = 2;
    localparam int TIMEOUT = 100;
    localparam int BLINK   = 10;

    localparam int M_IDLE  = 0;
    localparam int M_TRACK = 1;
    localparam int M_STALE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pos_data = 8'h00;
    logic        pos_valid = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] led_on;
    logic        link_ok;

    int n_chk = 0;
    int n_pass = 0;
    int n_printed = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    led_position_display #(
        .DATA_W         (DATA_W),
        .AVG_LOG2       (AVG_L2),
        .TIMEOUT_CYCLES (TIMEOUT),
        .BLINK_CYCLES   (BLINK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pos_data  (pos_data),
        .pos_valid (pos_valid),
        .mode      (mode),
        .led_on    (led_on),
        .link_ok   (link_ok)
    );

    // Behavioural model: sliding window of the last four samples,
    // "cycles since last sample" and "cycles spent stale".
    int          m_state = M_IDLE;
    int          win [4] = '{default: 0};
    int          quiet = 0;
    int          age = 0;
    logic [15:0] exp_led = 16'h0000;
    logic        exp_link = 1'b0;

    function automatic logic [15:0] expect_pattern(input int a, input logic bar_mode);
        int level;
        level = a / 16;
        if (bar_mode) return 16'((1 << (level + 1)) - 1);
        return 16'(1 << level);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state  <= M_IDLE;
            quiet    <= 0;
            age      <= 0;
            exp_led  <= 16'h0000;
            exp_link <= 1'b0;
            for (int i = 0; i < 4; i++) win[i] <= 0;
        end else begin
            case (m_state)
                M_TRACK: exp_led <= expect_pattern((win[0] + win[1] + win[2] + win[3]) / 4, mode);
                M_STALE: exp_led <= (((age / BLINK) % 2) == 0) ? 16'hFFFF : 16'h0000;
                default: exp_led <= 16'h0000;
            endcase
            exp_link <= (m_state == M_TRACK);
            if (pos_valid) begin
                if (m_state != M_TRACK) begin
                    for (int i = 0; i < 4; i++) win[i] <= int'(pos_data);
                end else begin
                    for (int i = 0; i < 3; i++) win[i] <= win[i+1];
                    win[3] <= int'(pos_data);
                end
                m_state <= M_TRACK;
                quiet   <= 0;
            end else if (m_state == M_TRACK) begin
                if (quiet + 1 == TIMEOUT) begin
                    m_state <= M_STALE;
                    age     <= 0;
                end else begin
                    quiet <= quiet + 1;
                end
            end else if (m_state == M_STALE) begin
                age <= age + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if (led_on === exp_led && link_ok === exp_link) begin
                n_pass++;
            end else if (n_printed < 20) begin
                n_printed++;
                $display("FAIL cycle_cmp t=%0t led_on=%h link_ok=%b expected led_on=%h link_ok=%b",
                         $time, led_on, link_ok, exp_led, exp_link);
            end
        end
    end

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h", name, got, want);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        pos_data  = d;
        pos_valid = 1'b1;
        @(negedge clk);
        pos_valid = 1'b0;
    endtask

    initial begin
        int n;

        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Idle after reset
        repeat (50) @(negedge clk);
        check_val("idle_led", led_on, 16'h0000);
        check_val("idle_link", 16'(link_ok), 16'h0001 ^ 16'h0001);

        // First sample prefills: 0x80 -> idx 8
        mode = 1'b1;
        send(8'h80);
        @(negedge clk);
        check_val("first_bar", led_on, 16'h01FF);
        check_val("first_link", 16'(link_ok), 16'h0001);
        mode = 1'b0;
        @(negedge clk);
        check_val("first_dot", led_on, 16'h0100);

        // Averaging toward 0xF0
        mode = 1'b1;
        send(8'hF0);
        @(negedge clk);
        check_val("avg_9c_bar", led_on, 16'h03FF);
        send(8'hF0);
        send(8'hF0);
        send(8'hF0);
        @(negedge clk);
        check_val("avg_f0_bar", led_on, 16'hFFFF);
        mode = 1'b0;
        @(negedge clk);
        check_val("avg_f0_dot", led_on, 16'h8000);
        mode = 1'b1;

        // Timeout into STALE and blink
        send(8'hF0);
        n = 0;
        while (link_ok && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("stale_delay", 16'(n), 16'd101);
        check_val("blink_first_on", led_on, 16'hFFFF);
        repeat (10) @(negedge clk);
        check_val("blink_off", led_on, 16'h0000);
        repeat (10) @(negedge clk);
        check_val("blink_on_again", led_on, 16'hFFFF);

        // Recovery with prefill of 0x00
        send(8'h00);
        @(negedge clk);
        check_val("recover_bar", led_on, 16'h0001);
        check_val("recover_link", 16'(link_ok), 16'h0001);

        // Sample exactly on the last quiet cycle keeps TRACK
        repeat (97) @(negedge clk);
        send(8'h10);
        @(negedge clk);
        check_val("edge_valid_link", 16'(link_ok), 16'h0001);
        check_val("edge_valid_led", led_on, 16'h0001);
        repeat (20) @(negedge clk);

        // Async reset in the middle of STALE
        n = 0;
        while (link_ok && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("stale_again", 16'(link_ok), 16'h0000);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_led", led_on, 16'h0000);
        check_val("async_rst_link", 16'(link_ok), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        mode = 1'b1;
        send(8'h40);
        @(negedge clk);
        check_val("post_rst_bar", led_on, 16'h001F);
        check_val("post_rst_link", 16'(link_ok), 16'h0001);

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
